// File: rtl/gf2_pkg.sv
// Shared types for the binary_matrix GF(2) blocks: FSM state encoding and an
// index-width helper.
package gf2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gf2_state_e;

  // Index width for n entries, never below one bit.
  function automatic int gf2_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gf2_col_reduce.sv
// Combinational GF(2) reduction: XOR of the P columns whose vector bit is set.
module gf2_col_reduce
  import gf2_pkg::*;
#(
  parameter int N = 3,
  parameter int P = 1
) (
  input  logic [P-1:0][N-1:0] cols,
  input  logic [P-1:0]        vbits,
  output logic [N-1:0]        red
);

  always_comb begin
    red = '0;
    for (int p = 0; p < P; p++) begin
      if (vbits[p]) begin
        red = red ^ cols[p];
      end else begin
        red = red;
      end
    end
  end

endmodule

// File: rtl/gf2_matvec_seq.sv
// Sequential GF(2) matrix-vector multiplier, P columns per cycle.
// Optional macro GF2_MATVEC_TRANSPOSE_EN adds the transpose port (computes A^T.v).
module gf2_matvec_seq
  import gf2_pkg::*;
#(
  parameter int N = 3,
  parameter int P = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_wr_en,
  input  logic [gf2_idx_w(N)-1:0]   a_wr_col,
  input  logic [N-1:0]              a_wr_data,
  output logic                      a_wr_ready,
  input  logic                      in_valid,
  input  logic [N-1:0]              in_data,
  output logic                      in_ready,
`ifdef GF2_MATVEC_TRANSPOSE_EN
  input  logic                      transpose,
`endif
  output logic                      out_valid,
  output logic [N-1:0]              out_data,
  input  logic                      out_ready
);

  localparam int IDX_W = gf2_idx_w(N);
  localparam int STEPS = N / P;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  gf2_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [N-1:0]             v_q, v_d;
  logic [N-1:0]             acc_q, acc_d;
  logic [N-1:0][N-1:0]      mat_q, mat_d;
`ifdef GF2_MATVEC_TRANSPOSE_EN
  logic                     tr_q, tr_d;
`endif

  logic [P-1:0][N-1:0]      sel_cols;
  logic [P-1:0]             sel_v;
  logic [N-1:0]             red;

  // Column group for this step; in transpose mode a "column" is a stored row.
  always_comb begin
    sel_cols = '0;
    sel_v    = '0;
    for (int p = 0; p < P; p++) begin
      if ((int'(cnt_q) * P + p) < N) begin
        sel_v[p] = v_q[IDX_W'(int'(cnt_q) * P + p)];
`ifdef GF2_MATVEC_TRANSPOSE_EN
        if (tr_q) begin
          for (int j = 0; j < N; j++) begin
            sel_cols[p][j] = mat_q[j][IDX_W'(int'(cnt_q) * P + p)];
          end
        end else begin
          sel_cols[p] = mat_q[IDX_W'(int'(cnt_q) * P + p)];
        end
`else
        sel_cols[p] = mat_q[IDX_W'(int'(cnt_q) * P + p)];
`endif
      end else begin
        sel_cols[p] = '0;
        sel_v[p]    = 1'b0;
      end
    end
  end

  gf2_col_reduce #(.N(N), .P(P)) u_reduce (
    .cols  (sel_cols),
    .vbits (sel_v),
    .red   (red)
  );

  // Matrix writes are dropped while busy and for out-of-range columns.
  always_comb begin
    mat_d = mat_q;
    if (a_wr_en && (state_q != BUSY) && (int'(a_wr_col) < N)) begin
      mat_d[a_wr_col] = a_wr_data;
    end else begin
      mat_d = mat_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    acc_d   = acc_q;
`ifdef GF2_MATVEC_TRANSPOSE_EN
    tr_d    = tr_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          v_d     = in_data;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef GF2_MATVEC_TRANSPOSE_EN
          tr_d    = transpose;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d = acc_q ^ red;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      v_q     <= '0;
      acc_q   <= '0;
      mat_q   <= '0;
`ifdef GF2_MATVEC_TRANSPOSE_EN
      tr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      acc_q   <= acc_d;
      mat_q   <= mat_d;
`ifdef GF2_MATVEC_TRANSPOSE_EN
      tr_q    <= tr_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign a_wr_ready = (state_q != BUSY);
  assign out_valid  = (state_q == DONE);
  assign out_data   = acc_q;

endmodule

// File: tb/tb_gf2_matvec_seq.sv
// Randomised bench for gf2_matvec_seq (N=6, P=2) against a GF(2) reference model.
module tb_gf2_matvec_seq;

  localparam int N     = 6;
  localparam int P     = 2;
  localparam int STEPS = N / P;
  localparam int IW    = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          a_wr_en;
  logic [IW-1:0] a_wr_col;
  logic [N-1:0]  a_wr_data;
  logic          a_wr_ready;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic          transpose;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          out_ready;

  bit am [N][N];  // am[i][j] = A_i_j
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gf2_matvec_seq #(.N(N), .P(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_wr_en    (a_wr_en),
    .a_wr_col   (a_wr_col),
    .a_wr_data  (a_wr_data),
    .a_wr_ready (a_wr_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
`ifdef GF2_MATVEC_TRANSPOSE_EN
    .transpose  (transpose),
`endif
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_mv(input logic [N-1:0] v, input bit tr);
    logic [N-1:0] u;
    bit a;
    u = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        a = tr ? am[j][i] : am[i][j];
        u[j] = u[j] ^ (a & v[i]);
      end
    end
    return u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_wr(input int c, input logic [N-1:0] d);
    if (c < N) begin
      for (int j = 0; j < N; j++) am[c][j] = d[j];
    end
  endtask

  task automatic wr_col(input int c, input logic [N-1:0] d);
    a_wr_en   = 1'b1;
    a_wr_col  = IW'(c);
    a_wr_data = d;
    chk("wr_ready_idle", {31'd0, a_wr_ready}, 32'd1);
    tick();
    a_wr_en = 1'b0;
    model_wr(c, d);
  endtask

  // wr_mode: 0 none, 1 write on the accept edge, 2 write attempt in first BUSY cycle
  task automatic run_vec(input logic [N-1:0] v, input bit tr, input int hold,
                         input int wr_mode, input int wr_c, input logic [N-1:0] wr_d);
    logic [N-1:0] exp;
    in_valid  = 1'b1;
    in_data   = v;
    transpose = tr;
    if (wr_mode == 1) begin
      a_wr_en   = 1'b1;
      a_wr_col  = IW'(wr_c);
      a_wr_data = wr_d;
    end
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid  = 1'b0;
    a_wr_en   = 1'b0;
    transpose = ~tr;
    if (wr_mode == 1) model_wr(wr_c, wr_d);
`ifdef GF2_MATVEC_TRANSPOSE_EN
    exp = ref_mv(v, tr);
`else
    exp = ref_mv(v, 1'b0);
`endif
    for (int k = 0; k < STEPS; k++) begin
      chk("busy_valid", {31'd0, out_valid}, 32'd0);
      chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      chk("busy_wr_ready", {31'd0, a_wr_ready}, 32'd0);
      if (k == 0 && wr_mode == 2) begin
        a_wr_en   = 1'b1;
        a_wr_col  = IW'(wr_c);
        a_wr_data = wr_d;
      end
      tick();
      a_wr_en = 1'b0;
    end
    chk("done_valid", {31'd0, out_valid}, 32'd1);
    chk("out_data", {{(32-N){1'b0}}, out_data}, {{(32-N){1'b0}}, exp});
    for (int h = 0; h < hold; h++) begin
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {{(32-N){1'b0}}, out_data}, {{(32-N){1'b0}}, exp});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_valid", {31'd0, out_valid}, 32'd0);
  endtask

  function automatic bit rand_tr();
`ifdef GF2_MATVEC_TRANSPOSE_EN
    return bit'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    rst = 1'b1; a_wr_en = 1'b0; a_wr_col = '0; a_wr_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; transpose = 1'b0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) am[i][j] = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wr_ready", {31'd0, a_wr_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {{(32-N){1'b0}}, out_data}, 32'd0);

    // identity: u = v
    for (int i = 0; i < N; i++) wr_col(i, N'(1) << i);
    run_vec(6'b000101, 1'b0, 0, 0, 0, '0);
    run_vec(6'b110010, 1'b0, 0, 0, 0, '0);
    // all-ones matrix, with backpressure
    for (int i = 0; i < N; i++) wr_col(i, '1);
    run_vec(6'b000111, 1'b0, 5, 0, 0, '0);
    run_vec(6'b000011, 1'b0, 0, 0, 0, '0);
    run_vec('1, 1'b0, 2, 0, 0, '0);
    // random matrix, dropped write during BUSY, write on the accept edge
    for (int i = 0; i < N; i++) wr_col(i, N'($urandom));
    run_vec(N'($urandom), 1'b0, 0, 2, 0, '1);
    run_vec(N'($urandom), 1'b0, 0, 0, 0, '0);
    run_vec(N'($urandom), 1'b0, 1, 1, 2, N'($urandom));
    // out-of-range columns are ignored
    wr_col(6, '1);
    wr_col(7, '1);
    run_vec('1, 1'b0, 0, 0, 0, '0);

    // reset in the second BUSY cycle
    in_valid = 1'b1; in_data = N'($urandom);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) am[i][j] = 1'b0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_wr_ready", {31'd0, a_wr_ready}, 32'd1);
    chk("midrst_out_data", {{(32-N){1'b0}}, out_data}, 32'd0);
    for (int k = 0; k < STEPS + 2; k++) begin
      chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    run_vec('1, 1'b0, 0, 0, 0, '0);

    // randomised traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_col(int'($urandom_range(0, 7)), N'($urandom));
      end
      run_vec(N'($urandom), rand_tr(), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 7)), N'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gf2_matvec_seq.md
# gf2_matvec_seq

Sequential, parametrised GF(2) matrix-vector multiplier. Computes u = A·v over GF(2) (AND products, XOR accumulation) for an N×N binary matrix held in internal registers. Processes P columns per cycle. Sits behind the combinational 3×3 matrix/vector blocks in the binary_matrix library, for dimensions where a flat XOR tree is too wide or too slow. Matrix load and vector/result streams use valid/ready handshakes.

## Interface
Parameters:
- N, default 3: matrix dimension and vector width; N ≥ 2.
- P, default 1: columns reduced per cycle; 1 ≤ P ≤ N, N % P == 0.

Ports:
- clk  in  1: the single clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- a_wr_en  in  1: column-write request.
- a_wr_col  in  $clog2(N): column index i.
- a_wr_data  in  N: column i; bit j is A_i_j.
- a_wr_ready  out  1: column write accepted this cycle when high.
- in_valid  in  1: vector v is valid.
- in_data  in  N: v; bit i is v_i.
- in_ready  out  1: block accepts v this cycle.
- out_valid  out  1: result valid.
- out_data  out  N: u; bit j is u_j = XOR over i of (A_i_j & v_i).
- out_ready  in  1: consumer accepts u.
- transpose  in  1: present only with GF2_MATVEC_TRANSPOSE_EN (see Configuration).

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid & in_ready: latch v, clear accumulator, cnt=0 → BUSY.
- BUSY: each cycle, acc ^= XOR over p in [0,P) of (v[cnt·P+p] ? column[cnt·P+p] : 0); cnt++. After N/P BUSY cycles → DONE.
- DONE: out_valid=1, out_data=acc, both held stable until out_ready; on out_valid & out_ready → IDLE.
- in_ready is high only in IDLE; no new vector is accepted in BUSY or DONE.
- Matrix write: takes effect at the edge where a_wr_en & a_wr_ready. a_wr_ready = (state != BUSY). a_wr_en while a_wr_ready=0 is dropped, not queued. a_wr_col ≥ N is ignored.
- Write on the same edge as vector accept is applied; that computation uses the new column.
- Widths: cnt is $clog2(N/P+1) bits; acc is N bits; no carries exist.

## Timing
- Reset: state=IDLE, matrix=0, acc=0, cnt=0. Outputs in the first post-reset cycle: in_ready=1, a_wr_ready=1, out_valid=0, out_data=0.
- Latency: vector accepted at edge t → out_valid=1 in the cycle after edge t+N/P (N=3, P=1: 3 BUSY cycles).
- Throughput with out_ready held high: one vector per N/P+2 cycles.
- out_data is registered and does not change while out_valid=1 and out_ready=0.
- Reset mid-BUSY or mid-DONE: computation is discarded, no out_valid is produced, and the matrix is cleared.

## Configuration
- GF2_MATVEC_TRANSPOSE_EN defined: the transpose port exists and is sampled with v at accept. When it is 1, the result is u_j = XOR over i of (A_j_i & v_i), using row-wise selection of the same storage. The mode is held for the whole computation.
- Undefined: the port is absent and the block always computes A·v. Logic for row selection is not generated.

## Structure
- Shared package gf2_pkg: state enum typedef (IDLE/BUSY/DONE) and an index-width helper constant function. The binary_matrix blocks reuse both.
- One sub-module, gf2_col_reduce: combinational, parameters N and P. Inputs are P columns and P vector bits; output is the N-bit XOR of the selected columns. It is instantiated once.

## Test plan
- Identity load (N=3, P=1), v=3'b101 → out_valid three cycles after the cycle following accept; u=3'b101.
- All-ones matrix: v=3'b111 → u=3'b111; v=3'b011 → u=3'b000.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_data stable, in_ready=0; out_ready=1 → IDLE next cycle.
- Write during BUSY: a_wr_en=1, col 0, data 3'b111 → a_wr_ready=0, matrix unchanged, result matches the pre-write matrix.
- rst asserted in second BUSY cycle → out_valid never rises; next cycle in_ready=1; next result uses an all-zero matrix (u=0).
- N=8, P=4, random A and v over 1000 vectors → matches software GF(2) model; with GF2_MATVEC_TRANSPOSE_EN and transpose=1 → matches Aᵀ·v.
